// File: rtl/address_decoder_ram_if.sv
// Load/store bus between core-side master and the data-memory front end.
// Carries request fields plus decoded strobes and registered read data.
interface address_decoder_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  logic              wen;
  logic              ren;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              wen1;
  logic              wen2;
  logic              wen3;
  logic [1:0]        out_sel;

  modport master (
    output wen, ren, waddr, raddr, wdata,
    input  rdata, wen1, wen2, wen3, out_sel
  );

  modport slave (
    input  wen, ren, waddr, raddr, wdata,
    output rdata, wen1, wen2, wen3, out_sel
  );
endinterface

// File: rtl/address_decoder_ram.sv
// Data-memory front end: region decoder on waddr plus a
// 4096x32 read-before-write RAM with one-cycle read latency.
module address_decoder_ram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 14,
  parameter int RAM_WORDS = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  address_decoder_ram_if.slave  bus
);
  localparam int AW = $clog2(RAM_WORDS);

  logic [DATA_W-1:0] mem [RAM_WORDS];
  logic [AW-1:0]     widx;
  logic [AW-1:0]     ridx;
  logic              unused_raddr_hi;

  assign widx = bus.waddr[AW-1:0];
  assign ridx = bus.raddr[AW-1:0];
  assign unused_raddr_hi = ^bus.raddr[ADDR_W-1:AW];

  // Region decode: RAM low 4K words, 16 I/O words at 0x1000, rest external
  always_comb begin
    bus.out_sel = 2'd2;
    unique case (1'b1)
      (bus.waddr[13:12] == 2'b00):   bus.out_sel = 2'd0;
      (bus.waddr[13:4] == 10'h100):  bus.out_sel = 2'd1;
      default:                       bus.out_sel = 2'd2;
    endcase
  end

  // Per-region strobes, all held low during reset
  always_comb begin
    bus.wen1 = bus.wen & rst_n & (bus.out_sel == 2'd0);
    bus.wen2 = bus.wen & rst_n & (bus.out_sel == 2'd1);
    bus.wen3 = bus.wen & rst_n & (bus.out_sel == 2'd2);
  end

  // RAM array write; contents survive reset
  always_ff @(posedge clk) begin
    if (bus.wen1)
      mem[widx] <= bus.wdata;
  end

  // Registered read port; old data returned on same-word collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.rdata <= '0;
    else if (bus.ren)
      bus.rdata <= mem[ridx];
  end
endmodule

// File: tb/tb_address_decoder_ram.sv
// Scoreboard bench for address_decoder_ram: decoder boundaries,
// RAM read/write, read-before-write, wrap and async reset.
module tb_address_decoder_ram;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] model [4096];
  logic [31:0] exp_q [$];
  logic [31:0] hold;

  address_decoder_ram_if bus ();

  address_decoder_ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string tag,
                    input logic w, input logic [13:0] wa,
                    input logic [31:0] wd,
                    input logic r, input logic [13:0] ra);
    logic [31:0] e;
    bus.wen   = w;
    bus.waddr = wa;
    bus.wdata = wd;
    bus.ren   = r;
    bus.raddr = ra;
    if (r) exp_q.push_back(model[ra[11:0]]);
    if (w && wa[13:12] == 2'b00 && rst_n) model[wa[11:0]] = wd;
    cyc();
    bus.wen = 1'b0;
    bus.ren = 1'b0;
    if (r) begin
      if (exp_q.size() == 0) begin
        check({tag, "_q"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check(tag, bus.rdata, e);
        hold = e;
      end
    end
  endtask

  task automatic dec(input logic [13:0] a, input logic [1:0] sel);
    bus.waddr = a;
    bus.wen   = 1'b0;
    #1;
    check("sel", {30'd0, bus.out_sel}, {30'd0, sel});
    check("stb_off", {29'd0, bus.wen1, bus.wen2, bus.wen3}, 32'd0);
    bus.wen = 1'b1;
    #1;
    check("sel_w", {30'd0, bus.out_sel}, {30'd0, sel});
    check("stb_on", {29'd0, bus.wen1, bus.wen2, bus.wen3},
          {29'd0, sel == 2'd0, sel == 2'd1, sel == 2'd2});
    bus.wen = 1'b0;
    #1;
  endtask

  logic [13:0] dec_a [7];
  logic [1:0]  dec_s [7];

  initial begin
    total = 0;
    bad   = 0;
    hold  = '0;
    for (int i = 0; i < 4096; i++) model[i] = '0;
    dec_a = '{14'h0FFF, 14'h1000, 14'h100F, 14'h1010,
              14'h3FFF, 14'h0000, 14'h2000};
    dec_s = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd2};

    rst_n     = 1'b0;
    bus.wen   = 1'b1;
    bus.ren   = 1'b0;
    bus.waddr = 14'h0010;
    bus.raddr = '0;
    bus.wdata = '0;
    cyc();
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_stb", {29'd0, bus.wen1, bus.wen2, bus.wen3}, 32'd0);
    bus.wen = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    op("init3", 1, 14'h0003, 32'h0, 0, 0);
    op("init10", 1, 14'h0010, 32'h11111111, 0, 0);
    op("wr5", 1, 14'h0005, 32'h12345678, 0, 0);
    op("rd5", 0, 0, 0, 1, 14'h0005);
    cyc();
    cyc();
    check("hold", bus.rdata, hold);

    for (int i = 0; i < 7; i++) dec(dec_a[i], dec_s[i]);

    bus.wen   = 1'b1;
    bus.waddr = 14'h1003;
    bus.wdata = 32'hAAAA5555;
    #1;
    check("io_wen2", {31'd0, bus.wen2}, 32'd1);
    check("io_wen1", {31'd0, bus.wen1}, 32'd0);
    op("io_wr", 1, 14'h1003, 32'hAAAA5555, 0, 0);
    op("io_rd3", 0, 0, 0, 1, 14'h0003);

    op("wr7", 1, 14'h0007, 32'h1, 0, 0);
    op("rbw7", 1, 14'h0007, 32'h2, 1, 14'h0007);
    op("rd7", 0, 0, 0, 1, 14'h0007);

    op("diff", 1, 14'h0030, 32'h9, 1, 14'h0005);
    op("rd30", 0, 0, 0, 1, 14'h0030);

    op("wrabc", 1, 14'h0ABC, 32'hCAFEF00D, 0, 0);
    op("wrap", 0, 0, 0, 1, 14'h1ABC);
    op("wr3k", 1, 14'h3FFF, 32'h77777777, 0, 0);
    op("rdfff", 0, 0, 0, 1, 14'h0FFF);

    op("wr20", 1, 14'h0020, 32'hDEADBEEF, 0, 0);
    op("rd20", 0, 0, 0, 1, 14'h0020);
    rst_n = 1'b0;
    #1;
    check("async_rst", bus.rdata, 32'd0);
    bus.wen   = 1'b1;
    bus.waddr = 14'h0010;
    bus.wdata = 32'h55555555;
    bus.ren   = 1'b1;
    bus.raddr = 14'h0020;
    #1;
    check("rst_wen1", {31'd0, bus.wen1}, 32'd0);
    cyc();
    cyc();
    check("rst_rd", bus.rdata, 32'd0);
    bus.wen = 1'b0;
    bus.ren = 1'b0;
    rst_n   = 1'b1;
    #1;
    op("post10", 0, 0, 0, 1, 14'h0010);
    op("post20", 0, 0, 0, 1, 14'h0020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
